// File: rtl/matrix_read_sequencer.sv
// matrix_read_sequencer: walks one stored matrix through the storage block's
// edge-triggered read port and streams it out with line/frame markers.
// Optional column-major walk is enabled by defining MATRIX_SEQ_TRANSPOSE_EN.
module matrix_read_sequencer #(
  parameter int ELEM_WIDTH = 8,
  parameter int DIM_BITS   = 3,
  parameter int MAX_DIM    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3:0]            req_m,
  input  logic [3:0]            req_n,
  input  logic                  req_slot,
  input  logic                  abort,
`ifdef MATRIX_SEQ_TRANSPOSE_EN
  input  logic                  transpose,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [3:0]            query_m,
  output logic [3:0]            query_n,
  input  logic                  query_slot0_valid,
  input  logic                  query_slot1_valid,
  output logic                  rd_en,
  output logic [3:0]            rd_m,
  output logic [3:0]            rd_n,
  output logic                  rd_slot_idx,
  output logic [DIM_BITS-1:0]   rd_row_idx,
  output logic [DIM_BITS-1:0]   rd_col_idx,
  input  logic [ELEM_WIDTH-1:0] rd_elem,
  input  logic                  rd_elem_valid,
  output logic [ELEM_WIDTH-1:0] out_elem,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_row_last,
  output logic                  out_last
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  localparam logic [3:0] MAX_DIM_4 = 4'(MAX_DIM);

  state_t              state_q, state_d;
  logic [3:0]          m_q, n_q;
  logic                slot_q;
  logic [DIM_BITS-1:0] row_q, col_q;
  logic                done_q, err_q;
  logic [ELEM_WIDTH-1:0] elem_q;
  logic                row_last_q, last_q;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
  logic                tr_q;
`endif

  logic load, capture, advance, set_done, set_err;
  logic req_ok, slot_ok;
  logic [3:0] m_last, n_last;
  logic row_end, col_end;

  assign slot_ok = req_slot ? query_slot1_valid : query_slot0_valid;
  assign req_ok  = (req_m != 4'd0) && (req_m <= MAX_DIM_4) &&
                   (req_n != 4'd0) && (req_n <= MAX_DIM_4) && slot_ok;

  // End-of-row/column compares are done at the 4-bit dim width
  assign m_last  = m_q - 4'd1;
  assign n_last  = n_q - 4'd1;
  assign row_end = (4'(row_q) == m_last);
  assign col_end = (4'(col_q) == n_last);

  assign busy        = (state_q != IDLE);
  assign rd_en       = (state_q == ISSUE);
  assign out_valid   = (state_q == OUT);
  assign done        = done_q;
  assign err         = err_q;
  assign query_m     = (state_q == IDLE) ? req_m : m_q;
  assign query_n     = (state_q == IDLE) ? req_n : n_q;
  assign rd_m        = m_q;
  assign rd_n        = n_q;
  assign rd_slot_idx = slot_q;
  assign rd_row_idx  = row_q;
  assign rd_col_idx  = col_q;
  assign out_elem    = elem_q;
  assign out_row_last = row_last_q;
  assign out_last    = last_q;

  // Next-state and control strobes; abort overrides every other transition
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    set_done = 1'b0;
    set_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_ok) begin
            load    = 1'b1;
            state_d = ISSUE;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d = abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rd_elem_valid) begin
          capture = 1'b1;
          state_d = OUT;
        end else begin
          set_err = 1'b1;
          state_d = IDLE;
        end
      end
      OUT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (out_ready) begin
          if (last_q) begin
            set_done = 1'b1;
            state_d  = IDLE;
          end else begin
            advance = 1'b1;
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, latched request, walk indices, output data and pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      m_q        <= '0;
      n_q        <= '0;
      slot_q     <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      elem_q     <= '0;
      row_last_q <= 1'b0;
      last_q     <= 1'b0;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
      tr_q       <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done_q  <= set_done;
      err_q   <= set_err;
      if (load) begin
        m_q    <= req_m;
        n_q    <= req_n;
        slot_q <= req_slot;
        row_q  <= '0;
        col_q  <= '0;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
        tr_q   <= transpose;
`endif
      end
      if (capture) begin
        elem_q <= rd_elem;
        last_q <= row_end && col_end;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
        row_last_q <= tr_q ? row_end : col_end;
`else
        row_last_q <= col_end;
`endif
      end
      if (advance) begin
`ifdef MATRIX_SEQ_TRANSPOSE_EN
        if (tr_q) begin
          if (row_end) begin
            row_q <= '0;
            col_q <= col_q + DIM_BITS'(1);
          end else begin
            row_q <= row_q + DIM_BITS'(1);
          end
        end else
`endif
        begin
          if (col_end) begin
            col_q <= '0;
            row_q <= row_q + DIM_BITS'(1);
          end else begin
            col_q <= col_q + DIM_BITS'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_read_sequencer.sv
// Directed bench for matrix_read_sequencer with a small edge-triggered
// storage model whose element (r,c) holds r*n + c + 1.
module tb_matrix_read_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] req_m, req_n;
  logic       req_slot;
  logic       abort;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
  logic       transpose;
`endif
  logic       busy, done, err;
  logic [3:0] query_m, query_n;
  logic       v0, v1;
  logic       rd_en;
  logic [3:0] rd_m, rd_n;
  logic       rd_slot_idx;
  logic [2:0] rd_row_idx, rd_col_idx;
  logic [7:0] rd_elem;
  logic       rd_elem_valid;
  logic [7:0] out_elem;
  logic       out_valid, out_ready, out_row_last, out_last;

  int checks = 0;
  int errors = 0;

  int exp_e  [25];
  int exp_rl [25];
  int exp_l  [25];

  matrix_read_sequencer #(.ELEM_WIDTH(8), .DIM_BITS(3), .MAX_DIM(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req_m(req_m), .req_n(req_n),
    .req_slot(req_slot), .abort(abort),
`ifdef MATRIX_SEQ_TRANSPOSE_EN
    .transpose(transpose),
`endif
    .busy(busy), .done(done), .err(err),
    .query_m(query_m), .query_n(query_n),
    .query_slot0_valid(v0), .query_slot1_valid(v1),
    .rd_en(rd_en), .rd_m(rd_m), .rd_n(rd_n), .rd_slot_idx(rd_slot_idx),
    .rd_row_idx(rd_row_idx), .rd_col_idx(rd_col_idx),
    .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid),
    .out_elem(out_elem), .out_valid(out_valid), .out_ready(out_ready),
    .out_row_last(out_row_last), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Storage model: registered read on the rising edge where rd_en is high
  always @(posedge clk) begin
    if (rd_en) begin
      rd_elem       <= 8'(int'(rd_row_idx) * int'(rd_n) + int'(rd_col_idx) + 1);
      rd_elem_valid <= rd_slot_idx ? v1 : v0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run one m x n walk on slot 1; stall_idx >= 0 holds out_ready low 5 cycles on that element
  task automatic walk(input int m, input int n, input int stall_idx);
    int idx = 0;
    int cyc = 0;
    int stall_add = 0;
    bit fin = 1'b0;
    req_m = 4'(m); req_n = 4'(n); req_slot = 1'b1; start = 1'b1;
    #1;
    check("query_m_idle_follow", query_m, 32'(m));
    tick();
    start = 1'b0;
    req_m = 4'd0; req_n = 4'd0;
    #1;
    check("busy_after_start", busy, 1);
    check("rd_en_first_issue", rd_en, 1);
    check("query_m_latched", query_m, 32'(m));
    check("query_n_latched", query_n, 32'(n));
    while (!fin && cyc < 1000) begin
      tick();
      cyc++;
      if (done) begin
        fin = 1'b1;
      end else if (out_valid) begin
        check("elem_cycle", cyc, 32'(2 + 3 * idx + stall_add));
        check("out_elem", out_elem, 32'(exp_e[idx]));
        check("out_row_last", out_row_last, 32'(exp_rl[idx]));
        check("out_last", out_last, 32'(exp_l[idx]));
        if (idx == stall_idx) begin
          out_ready = 1'b0;
          repeat (5) begin
            tick();
            cyc++;
            check("stall_valid", out_valid, 1);
            check("stall_elem", out_elem, 32'(exp_e[idx]));
            check("stall_row_last", out_row_last, 32'(exp_rl[idx]));
            check("stall_rd_en", rd_en, 0);
          end
          out_ready = 1'b1;
          stall_add = 5;
        end
        idx++;
      end
    end
    check("walk_done_seen", fin, 1);
    check("walk_elem_count", idx, 32'(m * n));
    check("done_cycle", cyc, 32'(3 * m * n + stall_add));
    check("busy_at_done", busy, 0);
    check("err_at_done", err, 0);
    tick();
    check("done_one_cycle", done, 0);
  endtask

  task automatic load_rowmajor_2x3();
    exp_e  = '{default: 0};
    exp_rl = '{default: 0};
    exp_l  = '{default: 0};
    for (int i = 0; i < 6; i++) exp_e[i] = i + 1;
    exp_rl[2] = 1; exp_rl[5] = 1; exp_l[5] = 1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; req_m = '0; req_n = '0; req_slot = 1'b0;
    abort = 1'b0; out_ready = 1'b1; v0 = 1'b0; v1 = 1'b1;
`ifdef MATRIX_SEQ_TRANSPOSE_EN
    transpose = 1'b0;
`endif
    tick(); tick();
    rst_n = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_out_elem", out_elem, 0);

    // Plain 2x3 row-major walk
    load_rowmajor_2x3();
    walk(2, 3, -1);

    // Backpressure on element 2
    walk(2, 3, 1);

    // Rejected requests
    req_slot = 1'b1; req_m = 4'd0; req_n = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    check("rej_m0_err", err, 1);
    check("rej_m0_busy", busy, 0);
    tick();
    check("rej_m0_err_clear", err, 0);
    req_m = 4'd6; req_n = 4'd2; start = 1'b1;
    tick(); start = 1'b0;
    check("rej_m6_err", err, 1);
    check("rej_m6_busy", busy, 0);
    tick();
    req_m = 4'd2; req_n = 4'd2; req_slot = 1'b0; start = 1'b1;
    tick(); start = 1'b0;
    check("rej_slot_err", err, 1);
    check("rej_slot_busy", busy, 0);
    check("rej_slot_done", done, 0);
    tick();

    // Abort during WAIT of element 4 of a 5x5
    req_m = 4'd5; req_n = 4'd5; req_slot = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    repeat (10) tick();
    check("abort_pre_busy", busy, 1);
    check("abort_pre_rd_en", rd_en, 0);
    check("abort_pre_valid", out_valid, 0);
    abort = 1'b1;
    tick(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    tick();
    check("abort_done_late", done, 0);
    check("abort_err_late", err, 0);
    walk(2, 3, -1);

    // Slot invalidated mid-walk: read returns invalid
    req_m = 4'd2; req_n = 4'd3; req_slot = 1'b1; start = 1'b1;
    tick(); start = 1'b0;
    v1 = 1'b0;
    tick();
    check("inval_no_err_yet", err, 0);
    tick();
    check("inval_err", err, 1);
    check("inval_busy", busy, 0);
    check("inval_done", done, 0);
    v1 = 1'b1;
    tick();
    check("inval_err_clear", err, 0);

    // Reset mid-walk while an element is presented
    req_m = 4'd2; req_n = 4'd3; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    check("pre_reset_valid", out_valid, 1);
    check("pre_reset_elem", out_elem, 1);
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("midreset_busy", busy, 0);
    check("midreset_rd_en", rd_en, 0);
    check("midreset_valid", out_valid, 0);
    check("midreset_elem", out_elem, 0);
    check("midreset_row_last", out_row_last, 0);
    check("midreset_last", out_last, 0);
    check("midreset_rd_m", rd_m, 0);
    tick();
    check("post_reset_busy", busy, 0);

`ifdef MATRIX_SEQ_TRANSPOSE_EN
    // Column-major 2x3: 1,4,2,5,3,6
    exp_e  = '{default: 0};
    exp_rl = '{default: 0};
    exp_l  = '{default: 0};
    exp_e[0] = 1; exp_e[1] = 4; exp_e[2] = 2; exp_e[3] = 5; exp_e[4] = 3; exp_e[5] = 6;
    exp_rl[1] = 1; exp_rl[3] = 1; exp_rl[5] = 1; exp_l[5] = 1;
    transpose = 1'b1;
    walk(2, 3, -1);
    transpose = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
